// File: rtl/wf_switch_allocator.sv
// -----------------------------------------------------------------------------
// wf_switch_allocator
//
// Switch allocator for one router of a 2-D mesh NoC using West-First routing.
// Each of the NP output ports (0 Right, 1 Left, 2 Up, 3 Down, 4 Eject) picks
// one requesting input per cycle. Picks are round-robin among head flits.
// The winner of a multi-flit packet holds the output until its tail flit
// (wormhole lock). Every transfer needs a downstream credit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state, forces outputs to 0
//   req_valid  [NP]     input i has a flit at its buffer head
//   req_head   [NP]     that flit is a head flit
//   req_tail   [NP]     that flit is a tail flit (head+tail = single-flit packet)
//   req_route  [NP*NP]  one-hot output request of input i at [NP*i +: NP]
//   credit_in  [NP]     downstream of output o freed one slot (pulse)
//   grant_in   [NP]     dequeue strobe: input i's flit moves this cycle
//   out_valid  [NP]     output o carries a flit this cycle
//   out_sel    [3*NP]   source input of output o at [3*o +: 3], 0 when idle
//   locked     [NP]     output o is held by an in-flight packet (registered)
//   err        1        sticky protocol-error flag (registered)
// -----------------------------------------------------------------------------
module wf_switch_allocator #(
    parameter int NP      = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NP-1:0]       req_valid,
    input  logic [NP-1:0]       req_head,
    input  logic [NP-1:0]       req_tail,
    input  logic [NP*NP-1:0]    req_route,
    input  logic [NP-1:0]       credit_in,
    output logic [NP-1:0]       grant_in,
    output logic [NP-1:0]       out_valid,
    output logic [3*NP-1:0]     out_sel,
    output logic [NP-1:0]       locked,
    output logic                err
);

    typedef enum logic {ST_FREE, ST_LOCKED} state_t;

    logic [NP-1:0]   w_route_ok;     // input's route is exactly one-hot
    logic [NP-1:0]   w_owns;         // input currently owns some locked output
    logic [NP-1:0]   w_lock_vec;
    logic [NP-1:0]   w_gnt;
    logic [NP-1:0]   w_ovf;          // credit overflow per output
    logic [3*NP-1:0] w_owner_flat;
    logic [3*NP-1:0] w_src_flat;
    logic            w_err_set;
    logic            r_err;

    // Route sanity per input: non-zero and a single bit set.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_route
            logic [NP-1:0] w_r;
            assign w_r            = req_route[NP*gi +: NP];
            assign w_route_ok[gi] = (w_r != '0) && ((w_r & (w_r - NP'(1))) == '0);
        end
    endgenerate

    // An input can own at most one output: it only wins a head grant while
    // owning nothing, so this OR never merges two owners.
    always_comb begin
        w_owns = '0;
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                if (w_lock_vec[o] && (w_owner_flat[3*o +: 3] == 3'(i))) begin
                    w_owns[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NP; gi++) begin : g_out
            state_t          r_state;
            logic            r_lock;
            logic [2:0]      r_owner;
            logic [2:0]      r_rr_ptr;
            logic [CW-1:0]   r_credit;

            logic [NP-1:0]   w_cand;
            logic            w_found;
            logic [2:0]      w_pick;
            logic            w_pick_tail;
            logic            w_own_valid;
            logic            w_own_head;
            logic            w_own_tail;
            logic            w_gnt_loc;
            logic [2:0]      w_src_loc;
            int              w_idx;

            always_comb begin
                // Owners are excluded: a head from an owner is a protocol error.
                w_cand = '0;
                for (int i = 0; i < NP; i++) begin
                    w_cand[i] = req_valid[i] & req_head[i] & w_route_ok[i]
                              & req_route[NP*i + gi] & ~w_owns[i];
                end

                // Round-robin scan starting at r_rr_ptr.
                w_found = 1'b0;
                w_pick  = '0;
                w_idx   = 0;
                for (int k = 0; k < NP; k++) begin
                    w_idx = int'(r_rr_ptr) + k;
                    if (w_idx >= NP) w_idx = w_idx - NP;
                    for (int i = 0; i < NP; i++) begin
                        if (!w_found && (i == w_idx) && w_cand[i]) begin
                            w_found = 1'b1;
                            w_pick  = 3'(i);
                        end
                    end
                end

                w_pick_tail = 1'b0;
                w_own_valid = 1'b0;
                w_own_head  = 1'b0;
                w_own_tail  = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    if (w_pick == 3'(i)) w_pick_tail = req_tail[i];
                    if (r_owner == 3'(i)) begin
                        w_own_valid = req_valid[i];
                        w_own_head  = req_head[i];
                        w_own_tail  = req_tail[i];
                    end
                end

                if (r_state == ST_FREE) begin
                    w_gnt_loc = w_found && (r_credit != '0);
                    w_src_loc = w_pick;
                end else begin
                    w_gnt_loc = w_own_valid && !w_own_head && (r_credit != '0);
                    w_src_loc = r_owner;
                end
            end

            assign w_gnt[gi]                = w_gnt_loc;
            assign w_src_flat[3*gi +: 3]    = w_src_loc;
            assign w_lock_vec[gi]           = r_lock;
            assign w_owner_flat[3*gi +: 3]  = r_owner;
            assign w_ovf[gi]                = credit_in[gi] && !w_gnt_loc
                                              && (r_credit == CW'(CREDITS));
            assign out_valid[gi]            = w_gnt_loc && !reset;
            assign out_sel[3*gi +: 3]       = (w_gnt_loc && !reset) ? w_src_loc : 3'd0;
            assign locked[gi]               = r_lock;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state  <= ST_FREE;
                    r_lock   <= 1'b0;
                    r_owner  <= '0;
                    r_rr_ptr <= '0;
                    r_credit <= CW'(CREDITS);
                end else begin
                    case (r_state)
                        ST_FREE: begin
                            if (w_gnt_loc) begin
                                r_rr_ptr <= (w_src_loc == 3'(NP-1)) ? 3'd0 : w_src_loc + 3'd1;
                                // Single-flit packets pass through without locking.
                                if (!w_pick_tail) begin
                                    r_state <= ST_LOCKED;
                                    r_lock  <= 1'b1;
                                    r_owner <= w_src_loc;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (w_gnt_loc && w_own_tail) begin
                                r_state <= ST_FREE;
                                r_lock  <= 1'b0;
                            end
                        end
                    endcase

                    // Grant and returned credit in the same cycle cancel out;
                    // a return into a full counter is dropped (flagged as err).
                    if (w_gnt_loc && !credit_in[gi]) begin
                        r_credit <= r_credit - CW'(1);
                    end else if (!w_gnt_loc && credit_in[gi]
                                 && (r_credit != CW'(CREDITS))) begin
                        r_credit <= r_credit + CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        grant_in = '0;
        for (int i = 0; i < NP; i++) begin
            for (int o = 0; o < NP; o++) begin
                if (!reset && w_gnt[o] && (w_src_flat[3*o +: 3] == 3'(i))) begin
                    grant_in[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_err_set = |w_ovf;
        for (int i = 0; i < NP; i++) begin
            if (req_valid[i]) begin
                // Bad route, or a new head while still owning an output.
                if (req_head[i] && (!w_route_ok[i] || w_owns[i])) w_err_set = 1'b1;
                // Body/tail flit with no packet in flight.
                if (!req_head[i] && !w_owns[i]) w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_wf_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_wf_switch_allocator
//
// Directed bench for wf_switch_allocator. The stimulus process drives one
// vector per cycle and pushes the hand-computed response for that cycle into
// a scoreboard queue; the monitor samples the DUT on the falling edge and pops
// and compares one entry per presented cycle.
// -----------------------------------------------------------------------------
module tb_wf_switch_allocator;

    localparam int NP = 5;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_head;
    logic [NP-1:0]     req_tail;
    logic [NP*NP-1:0]  req_route;
    logic [NP-1:0]     credit_in;
    logic [NP-1:0]     grant_in;
    logic [NP-1:0]     out_valid;
    logic [3*NP-1:0]   out_sel;
    logic [NP-1:0]     locked;
    logic              err;

    typedef struct {
        string        name;
        logic [4:0]   gnt;
        logic [4:0]   ov;
        logic [14:0]  sel;
        logic [4:0]   lk;
        logic         er;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_popped  = 0;
    bit   stim_done = 1'b0;

    wf_switch_allocator #(.NP(5), .CREDITS(4), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_head  (req_head),
        .req_tail  (req_tail),
        .req_route (req_route),
        .credit_in (credit_in),
        .grant_in  (grant_in),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] rt(input int i, input logic [4:0] r);
        logic [24:0] v;
        v = '0;
        v[5*i +: 5] = r;
        return v;
    endfunction

    function automatic logic [14:0] sl(input int o, input logic [2:0] s);
        logic [14:0] v;
        v = '0;
        v[3*o +: 3] = s;
        return v;
    endfunction

    task automatic step(input string nm, input logic rst,
                        input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                        input logic [24:0] route, input logic [4:0] cin,
                        input logic [4:0] eg, input logic [4:0] eov,
                        input logic [14:0] esel, input logic [4:0] elk, input logic eer);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_head  = h;
        req_tail  = t;
        req_route = route;
        credit_in = cin;
        e.name = nm; e.gnt = eg; e.ov = eov; e.sel = esel; e.lk = elk; e.er = eer;
        sb.push_back(e);
        n_pushed++;
    endtask

    // Stimulus
    initial begin
        reset = 1'b1; req_valid = '0; req_head = '0; req_tail = '0;
        req_route = '0; credit_in = '0;

        // Reset state, and requests are ignored while reset is high
        step("rst_idle", 1, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        step("rst_gate", 1, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);

        // Single 3-flit packet, input 2 -> Right
        step("pkt_head", 0, 5'b00100, 5'b00100, 5'b00000, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("pkt_body", 0, 5'b00100, 5'b00000, 5'b00000, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00001, 0);
        step("pkt_tail", 0, 5'b00100, 5'b00000, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00001, 0);
        step("pkt_idle", 0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        // Right has CREDITS-3 = 1 left: one more grant, then stall
        step("pkt_cred_last",  0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("pkt_cred_empty", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);

        // Round-robin on Eject between inputs 1 and 3, credit returned every cycle
        step("rr_1a", 0, 5'b01010, 5'b01010, 5'b01010, rt(1, 5'b10000) | rt(3, 5'b10000), 5'b10000, 5'b00010, 5'b10000, sl(4, 3'd1), 5'b00000, 0);
        step("rr_3a", 0, 5'b01010, 5'b01010, 5'b01010, rt(1, 5'b10000) | rt(3, 5'b10000), 5'b10000, 5'b01000, 5'b10000, sl(4, 3'd3), 5'b00000, 0);
        step("rr_1b", 0, 5'b01010, 5'b01010, 5'b01010, rt(1, 5'b10000) | rt(3, 5'b10000), 5'b10000, 5'b00010, 5'b10000, sl(4, 3'd1), 5'b00000, 0);
        step("rr_3b", 0, 5'b01010, 5'b01010, 5'b01010, rt(1, 5'b10000) | rt(3, 5'b10000), 5'b10000, 5'b01000, 5'b10000, sl(4, 3'd3), 5'b00000, 0);

        // Wormhole lock on Up: input 0 owns it, input 4 waits for the release
        step("wh_head",       0, 5'b00001, 5'b00001, 5'b00000, rt(0, 5'b00100), 5'b00000, 5'b00001, 5'b00100, sl(2, 3'd0), 5'b00000, 0);
        step("wh_body_block", 0, 5'b10001, 5'b10000, 5'b10000, rt(0, 5'b00100) | rt(4, 5'b00100), 5'b00000, 5'b00001, 5'b00100, sl(2, 3'd0), 5'b00100, 0);
        step("wh_tail_block", 0, 5'b10001, 5'b10000, 5'b10001, rt(0, 5'b00100) | rt(4, 5'b00100), 5'b00000, 5'b00001, 5'b00100, sl(2, 3'd0), 5'b00100, 0);
        step("wh_release",    0, 5'b10000, 5'b10000, 5'b10000, rt(4, 5'b00100), 5'b00000, 5'b10000, 5'b00100, sl(2, 3'd4), 5'b00000, 0);

        // Credit stall on Down: input 1 streams, only 4 credits
        step("cs_head",  0, 5'b00010, 5'b00010, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b00000, 0);
        step("cs_b1",    0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_b2",    0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_b3",    0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_stall1",0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00000, 5'b00000, '0, 5'b01000, 0);
        step("cs_stall2",0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b01000, 5'b00000, 5'b00000, '0, 5'b01000, 0);
        step("cs_refill",0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_stall3",0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00000, 5'b00000, '0, 5'b01000, 0);
        step("cs_cin",   0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b01000, 5'b00000, 5'b00000, '0, 5'b01000, 0);
        step("cs_both",  0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b01000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_held",  0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00010, 5'b01000, sl(3, 3'd1), 5'b01000, 0);
        step("cs_stall4",0, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00000, 5'b00000, '0, 5'b01000, 0);

        // Multi-hot route: never granted, err next cycle
        step("err_route",    0, 5'b00001, 5'b00001, 5'b00001, rt(0, 5'b00110), 5'b00000, 5'b00000, 5'b00000, '0, 5'b01000, 0);
        step("err_route_fl", 0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b01000, 1);

        // Reset mid-packet (Down still locked, err set) clears everything at once
        step("rst_mid",  1, 5'b00010, 5'b00000, 5'b00000, rt(1, 5'b01000), 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        step("rst_rel",  0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        // Right credits back to 4
        step("cr_1", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("cr_2", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("cr_3", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("cr_4", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00100, 5'b00001, sl(0, 3'd2), 5'b00000, 0);
        step("cr_5", 0, 5'b00100, 5'b00100, 5'b00100, rt(2, 5'b00001), 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);

        // Body flit from an idle input
        step("err_body",    0, 5'b00100, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        step("err_body_fl", 0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 1);
        step("rst_2",       1, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);

        // Credit overflow on Left (already at 4)
        step("err_ovf",    0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00010, 5'b00000, 5'b00000, '0, 5'b00000, 0);
        step("err_ovf_fl", 0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 1);
        step("rst_3",      1, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 0);

        // Owner presents a new head while its output is locked
        step("oh_head",   0, 5'b00001, 5'b00001, 5'b00000, rt(0, 5'b00010), 5'b00000, 5'b00001, 5'b00010, sl(1, 3'd0), 5'b00000, 0);
        step("oh_head2",  0, 5'b00001, 5'b00001, 5'b00000, rt(0, 5'b00010), 5'b00000, 5'b00000, 5'b00000, '0, 5'b00010, 0);
        step("oh_err_fl", 0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00000, 5'b00000, 5'b00000, '0, 5'b00010, 1);

        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_popped++;
                n_checks++;
                if (grant_in !== e.gnt || out_valid !== e.ov || out_sel !== e.sel
                    || locked !== e.lk || err !== e.er) begin
                    n_fail++;
                    $display("FAIL %s: got grant_in=%b out_valid=%b out_sel=%h locked=%b err=%b, expected grant_in=%b out_valid=%b out_sel=%h locked=%b err=%b",
                             e.name, grant_in, out_valid, out_sel, locked, err,
                             e.gnt, e.ov, e.sel, e.lk, e.er);
                end else begin
                    $display("ok   %s: grant_in=%b out_valid=%b out_sel=%h locked=%b err=%b",
                             e.name, grant_in, out_valid, out_sel, locked, err);
                end
            end
            if (stim_done && sb.size() == 0) break;
        end
        n_checks++;
        if (n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL scoreboard_drain: compared %0d cycles, expected %0d", n_popped, n_pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete, time limit 200000 reached, expected completion");
        $fatal(1, "time limit expired");
    end

endmodule
